// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one add/sub/and/or/nor ALU between two requesters
// Ports: clk, rst (sync, active-high); req0/a0/b0/func0 -> ack0 and req1/a1/b1/func1 -> ack1;
//        out_ready -> out_valid, out, zero_flag, out_id; op_count counts consumed results.
module alu_arbiter #(
    parameter int size = 32,
    parameter int cnt_width = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0,
    input  logic [size-1:0]      a0,
    input  logic [size-1:0]      b0,
    input  logic [2:0]           func0,
    output logic                 ack0,
    input  logic                 req1,
    input  logic [size-1:0]      a1,
    input  logic [size-1:0]      b1,
    input  logic [2:0]           func1,
    output logic                 ack1,
    input  logic                 out_ready,
    output logic                 out_valid,
    output logic [size-1:0]      out,
    output logic                 zero_flag,
    output logic                 out_id,
    output logic [cnt_width-1:0] op_count
);
    typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;
    state_t state, state_nxt;
    logic accept, win, last_grant, id_r;
    logic [size-1:0] a_r, b_r, res;
    logic [2:0] func_r;
    always_ff @(posedge clk) state <= rst ? IDLE : state_nxt;
    always_comb begin
        accept    = (state == IDLE) && (req0 || req1);
        // on a tie the port that did not win last time gets the ALU
        win       = (req0 && req1) ? ~last_grant : req1;
        state_nxt = accept ? EXEC :
                    (state == EXEC) ? HOLD :
                    (state == HOLD && out_ready) ? IDLE : state;
    end
    always_comb begin
        res = (func_r == 3'd0) ? a_r + b_r :
              (func_r == 3'd1) ? a_r - b_r :
              (func_r == 3'd2) ? a_r & b_r :
              (func_r == 3'd3) ? a_r | b_r :
              (func_r == 3'd4) ? ~(a_r | b_r) : '0;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            out_valid  <= 1'b0;
            out        <= '0;
            zero_flag  <= 1'b0;
            out_id     <= 1'b0;
            op_count   <= '0;
            last_grant <= 1'b1;
            id_r       <= 1'b0;
            a_r        <= '0;
            b_r        <= '0;
            func_r     <= '0;
        end else begin
            ack0 <= accept && !win;
            ack1 <= accept && win;
            if (accept) begin
                a_r        <= win ? a1 : a0;
                b_r        <= win ? b1 : b0;
                func_r     <= win ? func1 : func0;
                id_r       <= win;
                last_grant <= win;
            end
            if (state == EXEC) begin
                out       <= res;
                zero_flag <= (res == '0);
                out_id    <= id_r;
                out_valid <= 1'b1;
            end else if (state == HOLD && out_ready) begin
                out_valid <= 1'b0;
                op_count  <= op_count + cnt_width'(1);
            end
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed vector and corner-sequence checks for alu_arbiter
module tb_alu_arbiter;
    logic clk = 1'b0;
    logic rst, req0, req1, out_ready;
    logic [31:0] a0, b0, a1, b1;
    logic [2:0] func0, func1;
    logic ack0, ack1, out_valid, zero_flag, out_id;
    logic [31:0] out;
    logic [15:0] op_count;
    int nchk = 0;
    int nfail = 0;
    logic [15:0] exp_cnt;
    logic [31:0] held;

    typedef struct {
        logic        port;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  f;
        logic [31:0] e_out;
        logic        e_z;
    } vec_t;
    vec_t vecs[11];

    always #5 clk = ~clk;

    alu_arbiter #(.size(32), .cnt_width(16)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .a0(a0), .b0(b0), .func0(func0), .ack0(ack0),
        .req1(req1), .a1(a1), .b1(b1), .func1(func1), .ack1(ack1),
        .out_ready(out_ready), .out_valid(out_valid), .out(out),
        .zero_flag(zero_flag), .out_id(out_id), .op_count(op_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_cnt = '0;
    endtask

    // DUT must be IDLE on entry; runs accept, exec and consume with fixed latency
    task automatic run_op(input vec_t v);
        if (v.port) begin
            req1 = 1'b1; a1 = v.a; b1 = v.b; func1 = v.f;
        end else begin
            req0 = 1'b1; a0 = v.a; b0 = v.b; func0 = v.f;
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("ack0", {31'd0, ack0}, {31'd0, ~v.port});
        check("ack1", {31'd0, ack1}, {31'd0, v.port});
        check("valid_during_exec", {31'd0, out_valid}, 32'd0);
        req0 = 1'b0; req1 = 1'b0;
        a0 = ~v.a; b0 = v.b ^ 32'h5a5a_5a5a; a1 = ~v.a; b1 = v.b + 32'd3;
        func0 = ~v.f; func1 = ~v.f;
        @(negedge clk);
        check("valid", {31'd0, out_valid}, 32'd1);
        check("out", out, v.e_out);
        check("zero_flag", {31'd0, zero_flag}, {31'd0, v.e_z});
        check("out_id", {31'd0, out_id}, {31'd0, v.port});
        check("ack_pulse", {30'd0, ack1, ack0}, 32'd0);
        @(negedge clk);
        exp_cnt = exp_cnt + 16'd1;
        check("valid_clear", {31'd0, out_valid}, 32'd0);
        check("op_count", {16'd0, op_count}, {16'd0, exp_cnt});
        check("out_kept", out, v.e_out);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{1'b0, 32'd7, 32'd5, 3'd1, 32'd2, 1'b0};
        vecs[1]  = '{1'b1, 32'hFFFF_FFFF, 32'd1, 3'd0, 32'd0, 1'b1};
        vecs[2]  = '{1'b1, 32'd0, 32'd1, 3'd1, 32'hFFFF_FFFF, 1'b0};
        vecs[3]  = '{1'b1, 32'd5, 32'd3, 3'd6, 32'd0, 1'b1};
        vecs[4]  = '{1'b0, 32'h0000_F0F0, 32'h0000_FF00, 3'd2, 32'h0000_F000, 1'b0};
        vecs[5]  = '{1'b0, 32'h0000_00F0, 32'h0000_000F, 3'd3, 32'h0000_00FF, 1'b0};
        vecs[6]  = '{1'b1, 32'd0, 32'd0, 3'd4, 32'hFFFF_FFFF, 1'b0};
        vecs[7]  = '{1'b0, 32'd9, 32'd9, 3'd5, 32'd0, 1'b1};
        vecs[8]  = '{1'b0, 32'd1, 32'd2, 3'd7, 32'd0, 1'b1};
        vecs[9]  = '{1'b1, 32'hFFFF_0000, 32'h0000_FFFF, 3'd4, 32'd0, 1'b1};
        vecs[10] = '{1'b0, 32'd3, 32'd4, 3'd0, 32'd7, 1'b0};

        req0 = 0; req1 = 0; a0 = 0; b0 = 0; a1 = 0; b1 = 0;
        func0 = 0; func1 = 0; out_ready = 0;
        do_reset();
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out", out, 32'd0);
        check("rst_zero", {31'd0, zero_flag}, 32'd0);
        check("rst_id", {31'd0, out_id}, 32'd0);
        check("rst_cnt", {16'd0, op_count}, 32'd0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_no_ack", {30'd0, ack1, ack0}, 32'd0);
            check("idle_no_valid", {31'd0, out_valid}, 32'd0);
        end

        for (int i = 0; i < 11; i++) run_op(vecs[i]);

        // tie: both held high, port 0 wins first after reset, then alternation
        do_reset();
        out_ready = 1'b1;
        req0 = 1'b1; a0 = 32'd3; b0 = 32'd4; func0 = 3'd0;
        req1 = 1'b1; a1 = 32'd0; b1 = 32'd0; func1 = 3'd4;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("rr_ack", {30'd0, ack1, ack0}, (k % 2) ? 32'd2 : 32'd1);
            @(negedge clk);
            check("rr_valid", {31'd0, out_valid}, 32'd1);
            check("rr_id", {31'd0, out_id}, (k % 2) ? 32'd1 : 32'd0);
            check("rr_out", out, (k % 2) ? 32'hFFFF_FFFF : 32'd7);
            @(negedge clk);
            check("rr_consumed", {31'd0, out_valid}, 32'd0);
        end
        req0 = 1'b0; req1 = 1'b0;
        check("rr_count", {16'd0, op_count}, 32'd4);

        // back-pressure with a pending port 1 request
        do_reset();
        out_ready = 1'b0;
        req0 = 1'b1; a0 = 32'd10; b0 = 32'd20; func0 = 3'd0;
        @(negedge clk);
        check("bp_ack0", {31'd0, ack0}, 32'd1);
        req0 = 1'b0;
        req1 = 1'b1; a1 = 32'd8; b1 = 32'd3; func1 = 3'd1;
        @(negedge clk);
        check("bp_valid", {31'd0, out_valid}, 32'd1);
        held = out;
        check("bp_out", held, 32'd30);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
            check("bp_hold_out", out, held);
            check("bp_no_ack1", {31'd0, ack1}, 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_drop", {31'd0, out_valid}, 32'd0);
        check("bp_ack1_wait", {31'd0, ack1}, 32'd0);
        check("bp_cnt", {16'd0, op_count}, 32'd1);
        @(negedge clk);
        check("bp_ack1", {31'd0, ack1}, 32'd1);
        req1 = 1'b0;
        @(negedge clk);
        check("bp_out1", out, 32'd5);
        check("bp_id1", {31'd0, out_id}, 32'd1);
        @(negedge clk);
        check("bp_cnt2", {16'd0, op_count}, 32'd2);

        // reset during EXEC
        out_ready = 1'b1;
        req0 = 1'b1; a0 = 32'd1; b0 = 32'd1; func0 = 3'd0;
        @(negedge clk);
        check("rx_ack0", {31'd0, ack0}, 32'd1);
        req0 = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rx_valid", {31'd0, out_valid}, 32'd0);
        check("rx_ack", {30'd0, ack1, ack0}, 32'd0);
        check("rx_cnt", {16'd0, op_count}, 32'd0);
        @(negedge clk);
        check("rx_no_result", {31'd0, out_valid}, 32'd0);

        // reset during HOLD, after a port 0 grant so only reset restores port 0 priority
        out_ready = 1'b0;
        req0 = 1'b1; a0 = 32'd6; b0 = 32'd1; func0 = 3'd0;
        @(negedge clk);
        check("rh_ack0", {31'd0, ack0}, 32'd1);
        req0 = 1'b0;
        @(negedge clk);
        check("rh_valid", {31'd0, out_valid}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rh_valid_clr", {31'd0, out_valid}, 32'd0);
        check("rh_out", out, 32'd0);
        check("rh_cnt", {16'd0, op_count}, 32'd0);
        check("rh_ack", {30'd0, ack1, ack0}, 32'd0);
        req0 = 1'b1; req1 = 1'b1;
        @(negedge clk);
        check("rh_tie_port0", {30'd0, ack1, ack0}, 32'd1);
        req0 = 1'b0; req1 = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule
